ts_pid_filter: RTL and testbench

Downstream of the MPEG-TS framer. Consumes its byte stream (`din`, `dinsync`, `dinstb`, `locked`), parses the 4-byte transport header of each 188-byte packet, and forwards only packets whose 13-bit PID matches a programmed value. It also checks continuity counters and keeps saturating statistics. Output uses the same strobe/sync byte protocol, so the next stage sees a clean single-PID stream.

---
 rtl/ts_pid_filter_pkg.sv | 30 +++
 rtl/ts_pid_filter_if.sv | 26 ++
 rtl/ts_pid_filter_sat_counter.sv | 21 ++
 rtl/ts_pid_filter.sv | 186 ++++++++++++++++++
 tb/tb_ts_pid_filter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ts_pid_filter_pkg.sv
// Shared MPEG-TS constants, header field offsets and types for the PID filter.
package ts_pkg;

  localparam int          TS_PKTLEN   = 188;
  localparam logic [7:0]  TS_SYNC     = 8'h47;
  localparam logic [12:0] TS_NULL_PID = 13'h1FFF;

  // Byte offsets of the transport header fields within a packet.
  localparam int TS_OFS_PID_HI = 1;
  localparam int TS_OFS_PID_LO = 2;
  localparam int TS_OFS_CC     = 3;

  // Bit positions inside the header bytes.
  localparam int TS_BIT_TEI     = 7;
  localparam int TS_BIT_PAYLOAD = 4;

  typedef enum logic [1:0] {
    HUNT,
    HDR,
    BODY
  } ts_state_t;

  // One hold-line slot: a byte plus its sync marker and an occupancy flag.
  typedef struct packed {
    logic       vld;
    logic       sync;
    logic [7:0] data;
  } ts_hold_t;

endpackage

// File: rtl/ts_pid_filter_if.sv
// Byte-stream bundle between the framer, the PID filter and the next stage.
interface ts_pid_filter_if;

  logic [7:0] din;
  logic       dinsync;
  logic       dinstb;
  logic       locked;
  logic [7:0] dout;
  logic       doutsync;
  logic       doutstb;
  logic       doutabort;
  logic       ccerr;

  // The filter consumes the framer stream and produces the filtered stream.
  modport slave (
    input  din, dinsync, dinstb, locked,
    output dout, doutsync, doutstb, doutabort, ccerr
  );

  // The environment drives the framer side and observes the filtered side.
  modport master (
    output din, dinsync, dinstb, locked,
    input  dout, doutsync, doutstb, doutabort, ccerr
  );

endinterface

// File: rtl/ts_pid_filter_sat_counter.sv
// Saturating event counter used for the filter statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Count events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!resetb || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ts_pid_filter.sv
// Single-PID filter for a framed MPEG-TS byte stream with continuity checking.
module ts_pid_filter import ts_pkg::*; #(
  parameter int PKTLEN   = TS_PKTLEN,
  parameter int CNTW     = 16,
  parameter bit DROP_TEI = 1'b1
) (
  input  logic            clk,
  input  logic            resetb,
  ts_pid_filter_if.slave  bus,
  input  logic [12:0]     cfg_pid,
  input  logic            cfg_en,
  output logic [CNTW-1:0] pktcnt,
  output logic [CNTW-1:0] dropcnt,
  output logic [CNTW-1:0] ccerrcnt
);

  localparam int              IDXW       = $clog2(PKTLEN);
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(PKTLEN - 1);
  localparam logic [IDXW-1:0] IDX_PID_LO = IDXW'(TS_OFS_PID_LO);
  localparam logic [IDXW-1:0] IDX_CC     = IDXW'(TS_OFS_CC);
  localparam logic [IDXW-1:0] IDX_ONE    = IDXW'(1);

  ts_state_t       state;
  ts_state_t       stateNext;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] idxNew;
  ts_hold_t        s0;
  ts_hold_t        s1;
  logic            passR;
  logic            fwdActive;
  logic            ccValid;
  logic [3:0]      lastCc;
  logic [3:0]      ccExp;
  logic [12:0]     cfgPidQ;
  logic [12:0]     pid;

  logic inPkt, atEnd, lossLock, goodSync, badSync, wrap, loss, huntSync, accept;
  logic passComb, atPid, atCc, qual, emit, ccChk, ccBad, abort;
  logic pktInc, dropInc;

  // Classify the current cycle: accepted byte, re-sync, or loss of framing.
  always_comb begin
    inPkt    = (state != HUNT);
    atEnd    = (idx == IDX_LAST);
    lossLock = inPkt & ~bus.locked;
    goodSync = inPkt & bus.locked & bus.dinstb &  bus.dinsync &  atEnd;
    badSync  = inPkt & bus.locked & bus.dinstb &  bus.dinsync & ~atEnd;
    wrap     = inPkt & bus.locked & bus.dinstb & ~bus.dinsync &  atEnd;
    loss     = lossLock | badSync | wrap;
    huntSync = (state == HUNT) & bus.locked & bus.dinstb & bus.dinsync;
    accept   = (inPkt & bus.locked & bus.dinstb & ~loss) | huntSync;
    idxNew   = bus.dinsync ? '0 : idx + 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state <= HUNT;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: track header and body phases, fall back to HUNT on loss.
  always_comb begin
    stateNext = state;
    case (state)
      HUNT: if (huntSync) stateNext = HDR;
      HDR: begin
        if (loss) begin
          stateNext = HUNT;
        end else if (accept && (idxNew == IDX_CC)) begin
          stateNext = BODY;
        end
      end
      BODY: begin
        if (loss) begin
          stateNext = HUNT;
        end else if (goodSync) begin
          stateNext = HDR;
        end
      end
      default: stateNext = HUNT;
    endcase
  end

  // Output decisions: PID match, emission qualifier, continuity check, abort.
  always_comb begin
    pid      = {s1.data[4:0], bus.din};
    passComb = (pid != TS_NULL_PID) && (!cfg_en || (pid == cfg_pid)) &&
               !(DROP_TEI && s1.data[TS_BIT_TEI]);
    atPid    = accept && (idxNew == IDX_PID_LO);
    atCc     = accept && (idxNew == IDX_CC);
    qual     = atPid ? passComb : passR;
    emit     = accept && s0.vld && qual;
    ccExp    = lastCc + 4'd1;
    ccChk    = atCc && passR && bus.din[TS_BIT_PAYLOAD];
    ccBad    = ccChk && ccValid && (bus.din[3:0] != ccExp) && (bus.din[3:0] != lastCc);
    abort    = loss && passR && fwdActive;
    pktInc   = atPid && passComb;
    dropInc  = atPid && !passComb;
  end

  // Hold line, packet bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      idx           <= '0;
      s0            <= '0;
      s1            <= '0;
      passR         <= 1'b0;
      fwdActive     <= 1'b0;
      ccValid       <= 1'b0;
      lastCc        <= '0;
      cfgPidQ       <= '0;
      bus.dout      <= '0;
      bus.doutsync  <= 1'b0;
      bus.doutstb   <= 1'b0;
      bus.doutabort <= 1'b0;
      bus.ccerr     <= 1'b0;
    end else begin
      bus.dout      <= '0;
      bus.doutsync  <= 1'b0;
      bus.doutstb   <= 1'b0;
      bus.doutabort <= abort;
      bus.ccerr     <= ccBad;
      cfgPidQ       <= cfg_pid;
      if (loss) begin
        idx       <= '0;
        s0        <= '0;
        s1        <= '0;
        passR     <= 1'b0;
        fwdActive <= 1'b0;
        ccValid   <= 1'b0;
      end else if (accept) begin
        if (emit) begin
          bus.doutstb  <= 1'b1;
          bus.dout     <= s0.data;
          bus.doutsync <= s0.sync;
        end
        s0  <= s1;
        s1  <= '{vld: 1'b1, sync: bus.dinsync, data: bus.din};
        idx <= idxNew;
        if (atPid) begin
          passR <= passComb;
        end
        if (emit && (idxNew == IDX_PID_LO)) begin
          fwdActive <= 1'b1;
        end else if (emit && (idxNew == IDX_ONE)) begin
          fwdActive <= 1'b0;
        end
        if (ccChk) begin
          lastCc  <= bus.din[3:0];
          ccValid <= 1'b1;
        end
      end
      if (cfg_pid != cfgPidQ) begin
        ccValid <= 1'b0;
      end
    end
  end

  sat_counter #(.W(CNTW)) u_pktcnt (
    .clk    (clk),
    .resetb (resetb),
    .inc    (pktInc),
    .clr    (1'b0),
    .cnt    (pktcnt)
  );

  sat_counter #(.W(CNTW)) u_dropcnt (
    .clk    (clk),
    .resetb (resetb),
    .inc    (dropInc),
    .clr    (1'b0),
    .cnt    (dropcnt)
  );

  sat_counter #(.W(CNTW)) u_ccerrcnt (
    .clk    (clk),
    .resetb (resetb),
    .inc    (ccBad),
    .clr    (1'b0),
    .cnt    (ccerrcnt)
  );

endmodule

// File: tb/tb_ts_pid_filter.sv
// Directed bench for ts_pid_filter: forwarding, dropping, continuity, lock loss, reset.
module tb_ts_pid_filter;

  logic        clk;
  logic        resetb;
  logic [12:0] cfg_pid;
  logic        cfg_en;
  logic [15:0] pktcnt;
  logic [15:0] dropcnt;
  logic [15:0] ccerrcnt;

  ts_pid_filter_if bus ();

  ts_pid_filter #(
    .PKTLEN   (188),
    .CNTW     (16),
    .DROP_TEI (1'b1)
  ) dut (
    .clk      (clk),
    .resetb   (resetb),
    .bus      (bus),
    .cfg_pid  (cfg_pid),
    .cfg_en   (cfg_en),
    .pktcnt   (pktcnt),
    .dropcnt  (dropcnt),
    .ccerrcnt (ccerrcnt)
  );

  int passCount = 0;
  int checkCount = 0;
  int abortCnt = 0;
  int ccerrCnt = 0;
  int abortBase;
  int ccerrBase;
  logic [8:0] outQ[$];
  logic [8:0] expQ[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every emitted byte with its sync flag, and count pulses.
  always @(negedge clk) begin
    if (bus.doutstb) outQ.push_back({bus.doutsync, bus.dout});
    if (bus.doutabort) abortCnt++;
    if (bus.ccerr) ccerrCnt++;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL timeout: simulation did not reach the end");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [7:0] pktByte(input logic [12:0] pid, input logic [3:0] cc,
                                         input logic tei, input int k);
    logic [7:0] kb;
    kb = 8'(k);
    if (k == 0) return 8'h47;
    if (k == 1) return {tei, 2'b00, pid[12:8]};
    if (k == 2) return pid[7:0];
    if (k == 3) return {4'b0001, cc};
    return kb ^ pid[7:0] ^ {cc, 4'h0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic s);
    @(negedge clk);
    bus.din     = b;
    bus.dinsync = s;
    bus.dinstb  = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.dinstb  = 1'b0;
      bus.dinsync = 1'b0;
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    resetb     = 1'b0;
    bus.dinstb = 1'b0;
    idle(3);
    resetb = 1'b1;
    idle(1);
    outQ.delete();
    expQ.delete();
  endtask

  task automatic sendRange(input logic [12:0] pid, input logic [3:0] cc, input logic tei,
                           input int first, input int last, input bit gap);
    for (int k = first; k <= last; k++) begin
      applyStimulus(pktByte(pid, cc, tei, k), k == 0);
      if (gap) idle(1);
    end
  endtask

  task automatic expectRange(input logic [12:0] pid, input logic [3:0] cc, input logic tei,
                             input int first, input int last);
    for (int k = first; k <= last; k++) begin
      expQ.push_back({k == 0, pktByte(pid, cc, tei, k)});
    end
  endtask

  // Two strobes of a following packet push the held tail bytes out.
  task automatic flush();
    applyStimulus(8'h47, 1'b1);
    applyStimulus(8'h00, 1'b0);
    idle(4);
  endtask

  task automatic compareStream(input string tag);
    int mism;
    int n;
    mism = 0;
    n = (outQ.size() < expQ.size()) ? outQ.size() : expQ.size();
    checkOutput({tag, " length"}, outQ.size(), expQ.size());
    for (int i = 0; i < n; i++) begin
      if (outQ[i] !== expQ[i]) mism++;
    end
    checkOutput({tag, " data"}, mism, 0);
    outQ.delete();
    expQ.delete();
  endtask

  initial begin
    resetb      = 1'b0;
    cfg_pid     = 13'h100;
    cfg_en      = 1'b1;
    bus.din     = 8'h00;
    bus.dinsync = 1'b0;
    bus.dinstb  = 1'b0;
    bus.locked  = 1'b1;

    // Reset state
    applyReset();
    checkOutput("reset doutstb", bus.doutstb, 0);
    checkOutput("reset doutsync", bus.doutsync, 0);
    checkOutput("reset dout", bus.dout, 0);
    checkOutput("reset doutabort", bus.doutabort, 0);
    checkOutput("reset ccerr", bus.ccerr, 0);
    checkOutput("reset pktcnt", pktcnt, 0);
    checkOutput("reset dropcnt", dropcnt, 0);
    checkOutput("reset ccerrcnt", ccerrcnt, 0);

    // Three matching packets, one strobe every other cycle
    $display("[TB] three matching packets");
    for (int p = 0; p < 3; p++) begin
      sendRange(13'h100, 4'(p), 1'b0, 0, 187, 1'b1);
      expectRange(13'h100, 4'(p), 1'b0, 0, 187);
    end
    flush();
    compareStream("t1 stream");
    checkOutput("t1 pktcnt", pktcnt, 3);
    checkOutput("t1 dropcnt", dropcnt, 0);
    checkOutput("t1 ccerrcnt", ccerrcnt, 0);

    // Interleaved PIDs, back-to-back strobes
    $display("[TB] interleaved PIDs");
    applyReset();
    for (int p = 0; p < 4; p++) begin
      sendRange(13'h100, 4'(p), 1'b0, 0, 187, 1'b0);
      expectRange(13'h100, 4'(p), 1'b0, 0, 187);
      sendRange(13'h200, 4'(p), 1'b0, 0, 187, 1'b0);
    end
    flush();
    compareStream("t2 stream");
    checkOutput("t2 pktcnt", pktcnt, 4);
    checkOutput("t2 dropcnt", dropcnt, 4);

    // Continuity sequence 5,6,6,9
    $display("[TB] continuity errors");
    applyReset();
    ccerrBase = ccerrCnt;
    sendRange(13'h100, 4'd5, 1'b0, 0, 187, 1'b0);
    sendRange(13'h100, 4'd6, 1'b0, 0, 187, 1'b0);
    sendRange(13'h100, 4'd6, 1'b0, 0, 187, 1'b0);
    checkOutput("t3 ccerrcnt after duplicate", ccerrcnt, 0);
    sendRange(13'h100, 4'd9, 1'b0, 0, 3, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("t3 ccerr pulse on idx3", bus.ccerr, 1);
    sendRange(13'h100, 4'd9, 1'b0, 4, 187, 1'b0);
    flush();
    checkOutput("t3 ccerrcnt", ccerrcnt, 1);
    checkOutput("t3 ccerr pulses", ccerrCnt - ccerrBase, 1);
    checkOutput("t3 pktcnt", pktcnt, 4);
    outQ.delete();

    // Null PID and TEI drops with filtering disabled
    $display("[TB] null PID and TEI");
    applyReset();
    cfg_en = 1'b0;
    sendRange(13'h1FFF, 4'd0, 1'b0, 0, 187, 1'b0);
    sendRange(13'h100, 4'd0, 1'b1, 0, 187, 1'b0);
    sendRange(13'h300, 4'd0, 1'b0, 0, 187, 1'b0);
    expectRange(13'h300, 4'd0, 1'b0, 0, 187);
    flush();
    compareStream("t4 stream");
    checkOutput("t4 dropcnt", dropcnt, 2);
    checkOutput("t4 pktcnt", pktcnt, 1);
    cfg_en = 1'b1;

    // Lock loss at idx 100 of a passed packet
    $display("[TB] lock loss");
    applyReset();
    abortBase = abortCnt;
    sendRange(13'h100, 4'd0, 1'b0, 0, 187, 1'b0);
    expectRange(13'h100, 4'd0, 1'b0, 0, 187);
    sendRange(13'h100, 4'd1, 1'b0, 0, 99, 1'b0);
    expectRange(13'h100, 4'd1, 1'b0, 0, 97);
    @(negedge clk);
    bus.locked  = 1'b0;
    bus.din     = pktByte(13'h100, 4'd1, 1'b0, 100);
    bus.dinsync = 1'b0;
    bus.dinstb  = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5 doutabort pulse", bus.doutabort, 1);
    @(negedge clk);
    bus.locked = 1'b1;
    bus.dinstb = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t5 doutabort one cycle", bus.doutabort, 0);
    sendRange(13'h100, 4'd1, 1'b0, 101, 187, 1'b0);
    idle(4);
    compareStream("t5 truncated stream");
    checkOutput("t5 abort pulses", abortCnt - abortBase, 1);
    checkOutput("t5 pktcnt before resync", pktcnt, 2);
    sendRange(13'h100, 4'd2, 1'b0, 0, 187, 1'b0);
    expectRange(13'h100, 4'd2, 1'b0, 0, 187);
    flush();
    compareStream("t5 resync stream");
    checkOutput("t5 pktcnt", pktcnt, 3);

    // Reset in the middle of back-to-back traffic
    $display("[TB] reset mid-packet");
    applyReset();
    abortBase = abortCnt;
    sendRange(13'h100, 4'd0, 1'b0, 0, 187, 1'b0);
    sendRange(13'h100, 4'd1, 1'b0, 0, 49, 1'b0);
    checkOutput("t6 pktcnt before reset", pktcnt, 2);
    @(negedge clk);
    resetb      = 1'b0;
    bus.din     = pktByte(13'h100, 4'd1, 1'b0, 50);
    bus.dinsync = 1'b0;
    bus.dinstb  = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6 doutstb after reset", bus.doutstb, 0);
    checkOutput("t6 dout after reset", bus.dout, 0);
    checkOutput("t6 pktcnt after reset", pktcnt, 0);
    checkOutput("t6 doutabort after reset", bus.doutabort, 0);
    idle(2);
    resetb = 1'b1;
    idle(2);
    checkOutput("t6 no abort pulse", abortCnt - abortBase, 0);
    checkOutput("t6 dropcnt", dropcnt, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
